// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU/mux select codes and the per-state control vector.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Alu_op codes, shared with the downstream ALU stage
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control-vector table (pure Moore decode, no gating).
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCS_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCS_JUMP;
      end
      S_ADDI_WB: ctrl_o.reg_write = 1'b1;
      default:   ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: state register, next-state logic, mem_ready
// gating, PC enable and retired-instruction counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       Alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic             is_load_q, is_load_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire, illegal, rdy, fetch_gate;
  ctrl_t            ctrl;

  assign rdy = USE_MEM_READY ? mem_ready : 1'b1;

  mips_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      is_load_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // lw/sw choice is captured in DECODE so later opcode changes cannot steer MEMADR
  always_comb begin
    state_d   = S_FETCH;
    is_load_d = is_load_q;
    retire    = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        is_load_d = (opcode == OP_LW);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = is_load_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_d = rdy ? S_FETCH : S_MEMWR;
        retire  = rdy;
      end
      S_EXEC:    state_d = S_ALUWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:   state_d = S_FETCH;
    endcase
  end

  // In reset every output is held low even though state already reads FETCH
  assign fetch_gate = (state_q == S_FETCH) ? rdy : 1'b1;

  assign pc_en      = reset_n & ((ctrl.pc_write & fetch_gate) | (ctrl.pc_write_cond & zero));
  assign iord       = reset_n & ctrl.iord;
  assign mem_read   = reset_n & ctrl.mem_read;
  assign mem_write  = reset_n & ctrl.mem_write;
  assign ir_write   = reset_n & ctrl.ir_write & fetch_gate;
  assign mem_to_reg = reset_n & ctrl.mem_to_reg;
  assign reg_dst    = reset_n & ctrl.reg_dst;
  assign reg_write  = reset_n & ctrl.reg_write;
  assign alu_src_a  = reset_n & ctrl.alu_src_a;
  assign alu_src_b  = {2{reset_n}} & ctrl.alu_src_b;
  assign Alu_op     = {2{reset_n}} & ctrl.alu_op;
  assign pc_source  = {2{reset_n}} & ctrl.pc_source;
  assign illegal_op = reset_n & illegal;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a 32-bit-counter instance and a
// 4-bit-counter instance share stimulus; outputs are packed and compared per cycle.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero, mem_ready;

  logic pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, Alu_op, pc_source;
  logic [31:0] retired;
  logic pc_en4, iord4, mem_read4, mem_write4, ir_write4, mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, illegal_op4;
  logic [1:0] alu_src_b4, Alu_op4, pc_source4;
  logic [3:0] retired4;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.USE_MEM_READY(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .Alu_op(Alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .retired(retired)
  );

  mips_multicycle_ctrl #(.USE_MEM_READY(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en4), .iord(iord4), .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
    .mem_to_reg(mem_to_reg4), .reg_dst(reg_dst4), .reg_write(reg_write4), .alu_src_a(alu_src_a4),
    .alu_src_b(alu_src_b4), .Alu_op(Alu_op4), .pc_source(pc_source4), .illegal_op(illegal_op4),
    .retired(retired4)
  );

  // {pc_en,iord,mem_read,mem_write, ir_write,mem_to_reg,reg_dst,reg_write,
  //  alu_src_a,alu_src_b, Alu_op,pc_source,illegal_op}
  logic [15:0] outv, outv4;
  assign outv  = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                  alu_src_a, alu_src_b, Alu_op, pc_source, illegal_op};
  assign outv4 = {pc_en4, iord4, mem_read4, mem_write4, ir_write4, mem_to_reg4, reg_dst4, reg_write4,
                  alu_src_a4, alu_src_b4, Alu_op4, pc_source4, illegal_op4};

  localparam logic [15:0] V_FETCH   = 16'hA820;
  localparam logic [15:0] V_FSTALL  = 16'h2020;
  localparam logic [15:0] V_DECODE  = 16'h0060;
  localparam logic [15:0] V_ILLEGAL = 16'h0061;
  localparam logic [15:0] V_ADDR    = 16'h00C0;
  localparam logic [15:0] V_MEMRD   = 16'h6000;
  localparam logic [15:0] V_MEMWB   = 16'h0500;
  localparam logic [15:0] V_MEMWR   = 16'h5000;
  localparam logic [15:0] V_EXEC    = 16'h0090;
  localparam logic [15:0] V_ALUWB   = 16'h0300;
  localparam logic [15:0] V_BR_T    = 16'h808A;
  localparam logic [15:0] V_BR_N    = 16'h008A;
  localparam logic [15:0] V_JUMP    = 16'h8004;
  localparam logic [15:0] V_ADDIWB  = 16'h0100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one cycle: drive at the negedge, check after settling, advance to next negedge
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [15:0] exp);
    mem_ready = mr;
    zero      = z;
    #1;
    chk(tag, {16'h0, outv}, {16'h0, exp});
    chk({tag, "_n4"}, {16'h0, outv4}, {16'h0, exp});
    chk({tag, "_excl"}, {31'h0, mem_read & mem_write}, 32'h0);
    @(negedge clk);
  endtask

  task automatic chk_ret(input string tag, input int n);
    chk(tag, retired, n);
    chk({tag, "_w4"}, {28'h0, retired4}, n % 16);
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out", {16'h0, outv}, 32'h0);
    chk_ret("rst_ret", 0);
    reset_n = 1'b1;

    // R-type
    opcode = 6'b000000;
    cyc("r_f", 1, 0, V_FETCH);
    cyc("r_d", 1, 0, V_DECODE);
    cyc("r_ex", 1, 0, V_EXEC);
    cyc("r_wb", 1, 0, V_ALUWB);
    chk_ret("r_ret", 1);

    // lw with two stall cycles; opcode changes after DECODE must be ignored
    opcode = 6'b100011;
    cyc("lw_f", 1, 0, V_FETCH);
    cyc("lw_d", 1, 0, V_DECODE);
    opcode = 6'b101011;
    cyc("lw_a", 1, 0, V_ADDR);
    opcode = 6'b000000;
    cyc("lw_rd0", 0, 0, V_MEMRD);
    cyc("lw_rd1", 0, 0, V_MEMRD);
    cyc("lw_rd2", 1, 0, V_MEMRD);
    cyc("lw_wb", 1, 0, V_MEMWB);
    chk_ret("lw_ret", 2);

    // sw with a fetch stall and a write stall
    opcode = 6'b101011;
    cyc("sw_fs", 0, 0, V_FSTALL);
    cyc("sw_f", 1, 0, V_FETCH);
    cyc("sw_d", 1, 0, V_DECODE);
    cyc("sw_a", 1, 0, V_ADDR);
    cyc("sw_w0", 0, 0, V_MEMWR);
    chk_ret("sw_hold", 2);
    cyc("sw_w1", 1, 0, V_MEMWR);
    chk_ret("sw_ret", 3);

    // beq taken and not taken
    opcode = 6'b000100;
    cyc("bt_f", 1, 0, V_FETCH);
    cyc("bt_d", 1, 0, V_DECODE);
    cyc("bt_b", 1, 1, V_BR_T);
    cyc("bn_f", 1, 0, V_FETCH);
    cyc("bn_d", 1, 0, V_DECODE);
    cyc("bn_b", 1, 0, V_BR_N);
    chk_ret("beq_ret", 5);

    // j and addi
    opcode = 6'b000010;
    cyc("j_f", 1, 0, V_FETCH);
    cyc("j_d", 1, 0, V_DECODE);
    cyc("j_j", 1, 0, V_JUMP);
    opcode = 6'b001000;
    cyc("ad_f", 1, 0, V_FETCH);
    cyc("ad_d", 1, 0, V_DECODE);
    cyc("ad_ex", 1, 0, V_ADDR);
    cyc("ad_wb", 1, 0, V_ADDIWB);
    chk_ret("ad_ret", 7);

    // illegal opcode
    opcode = 6'b111111;
    cyc("il_f", 1, 0, V_FETCH);
    cyc("il_d", 1, 0, V_ILLEGAL);
    cyc("il_back", 1, 0, V_FETCH);
    chk_ret("il_ret", 7);

    // reset mid-EXEC
    opcode = 6'b000000;
    cyc("rx_d", 1, 0, V_DECODE);
    mem_ready = 1'b1;
    #1 chk("rx_ex", {16'h0, outv}, {16'h0, V_EXEC});
    reset_n = 1'b0;
    #1 chk("rx_out", {16'h0, outv}, 32'h0);
    chk("rx_out4", {16'h0, outv4}, 32'h0);
    chk_ret("rx_ret", 0);
    @(negedge clk);
    chk("rx_hold", {16'h0, outv}, 32'h0);
    reset_n = 1'b1;
    cyc("rx_f", 1, 0, V_FETCH);
    cyc("rx_d2", 1, 0, V_DECODE);
    cyc("rx_ex2", 1, 0, V_EXEC);
    cyc("rx_wb", 1, 0, V_ALUWB);
    chk_ret("rx_ret1", 1);

    // 16 jumps: 4-bit counter wraps back to 1
    opcode = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      cyc("wr_f", 1, 0, V_FETCH);
      cyc("wr_d", 1, 0, V_DECODE);
      cyc("wr_j", 1, 0, V_JUMP);
      chk_ret("wr_ret", i + 2);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
